// File: rtl/instr_scheduler.sv
// Instruction FIFO and issue sequencer for the systolic array controller.
// Optional stall performance counter enabled by defining SCHED_PERF_CNT_EN.
module instr_scheduler #(
  parameter int DEPTH       = 8,
  parameter int COMPUTE_LAT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              in_instr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     resume,
  output logic [63:0]              instr_out,
  output logic                     instr_valid,
  output logic                     busy,
  output logic                     halted,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              stall_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(COMPUTE_LAT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] LAT_C   = WAIT_W'(COMPUTE_LAT);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HALTED} state_t;
  typedef enum logic [1:0] {OP_FWD, OP_COMPUTE, OP_HALT, OP_ILLEGAL} op_class_t;

  function automatic op_class_t classify(input logic [4:0] op);
    if (op == 5'd1 || op == 5'd2) return OP_COMPUTE;
    if (op == 5'd31)              return OP_HALT;
    if (op <= 5'd7)               return OP_FWD;
    return OP_ILLEGAL;
  endfunction

  logic [63:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  state_t            state_q, state_d;
  logic              push, pop, vld_d, err_d;
  logic [63:0]       head, out_d;

  assign in_ready = (count != DEPTH_C);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state_q == S_WAIT) || (count != '0);
  assign halted   = (state_q == S_HALTED);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pop     = 1'b0;
    out_d   = '0;
    vld_d   = 1'b0;
    err_d   = err;
    unique case (state_q)
      S_ISSUE: begin
        if (count != '0) begin
          pop = 1'b1;
          unique case (classify(head[4:0]))
            OP_COMPUTE: begin
              out_d   = head;
              vld_d   = 1'b1;
              wcnt_d  = LAT_C;
              state_d = S_WAIT;
            end
            OP_HALT:    state_d = S_HALTED;
            OP_FWD: begin
              out_d = head;
              vld_d = 1'b1;
            end
            OP_ILLEGAL: err_d = 1'b1;
          endcase
        end
      end
      S_WAIT: begin
        // Leaves WAIT on the edge where the counter reaches zero.
        if (wcnt_q != '0) wcnt_d = wcnt_q - WAIT_W'(1);
        if (wcnt_q <= WAIT_W'(1)) state_d = S_ISSUE;
      end
      S_HALTED: if (resume) state_d = S_ISSUE;
      default:  state_d = S_ISSUE;
    endcase
  end

  // FIFO storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // Control and issue register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_ISSUE;
      wcnt_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      instr_out   <= out_d;
      instr_valid <= vld_d;
      err         <= err_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SCHED_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == S_WAIT || state_q == S_HALTED) && count != '0) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_scheduler.sv
// Self-checking bench for instr_scheduler: directed scenarios with literal
// expectations plus randomized traffic compared to a queue-based model.
module tb_instr_scheduler;
  localparam int DEPTH = 8;
  localparam int LAT   = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   in_instr;
  logic          in_valid;
  logic          in_ready;
  logic          resume;
  logic [63:0]   instr_out;
  logic          instr_valid;
  logic          busy;
  logic          halted;
  logic          err;
  logic [CW-1:0] count;
  logic [15:0]   stall_cnt;

  instr_scheduler #(.DEPTH(DEPTH), .COMPUTE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .resume(resume), .instr_out(instr_out),
    .instr_valid(instr_valid), .busy(busy), .halted(halted), .err(err),
    .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: queue of pending instructions, the edge number before
  // which no pop may happen, and halt/err/stall bookkeeping.
  logic [63:0] q[$];
  int          cyc = 0;
  int          blocked_until = 0;
  bit          m_halted = 0;
  bit          m_err = 0;
  logic [63:0] m_out = '0;
  bit          m_vld = 0;
  int          m_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] mk(input logic [4:0] op);
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    v[4:0] = op;
    return v;
  endfunction

  function automatic logic [4:0] fwd_op();
    int r;
    r = $urandom_range(0, 5);
    return (r == 0) ? 5'd0 : 5'(r + 2);
  endfunction

  task automatic model_reset();
    q.delete();
    blocked_until = 0;
    m_halted = 0;
    m_err = 0;
    m_out = '0;
    m_vld = 0;
    m_stall = 0;
  endtask

  task automatic model_edge();
    int          e;
    int          pre_size;
    bit          pre_wait, pre_halt, do_push, do_pop;
    logic [63:0] h;
    logic [4:0]  op;
    e        = cyc;
    pre_wait = (e < blocked_until);
    pre_halt = m_halted;
    pre_size = q.size();
    do_push  = in_valid && (pre_size < DEPTH);
    do_pop   = !pre_halt && !pre_wait && (pre_size > 0);
    m_out = '0;
    m_vld = 0;
`ifdef SCHED_PERF_CNT_EN
    if ((pre_wait || pre_halt) && pre_size > 0 && m_stall < 65535) m_stall++;
`endif
    if (pre_halt && resume) m_halted = 0;
    if (do_pop) begin
      h  = q.pop_front();
      op = h[4:0];
      if (op == 5'd1 || op == 5'd2) begin
        m_out = h;
        m_vld = 1;
        blocked_until = e + LAT + 1;
      end else if (op == 5'd31) begin
        m_halted = 1;
      end else if (op <= 5'd7) begin
        m_out = h;
        m_vld = 1;
      end else begin
        m_err = 1;
      end
    end
    if (do_push) q.push_back(in_instr);
    cyc++;
  endtask

  task automatic compare_outputs();
    chk("instr_out",   instr_out, m_out);
    chk("instr_valid", 64'(instr_valid), 64'(m_vld));
    chk("in_ready",    64'(in_ready), 64'(q.size() < DEPTH));
    chk("count",       64'(count), 64'(q.size()));
    chk("busy",        64'(busy), 64'((cyc < blocked_until) || (q.size() > 0)));
    chk("halted",      64'(halted), 64'(m_halted));
    chk("err",         64'(err), 64'(m_err));
    chk("stall_cnt",   64'(stall_cnt), 64'(m_stall));
  endtask

  task automatic step(input bit v, input logic [63:0] d, input bit r);
    in_valid = v;
    in_instr = d;
    resume   = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_instr_out"}, instr_out, 64'h0);
    chk({tag, "_instr_valid"}, 64'(instr_valid), 64'h0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'h1);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_halted"}, 64'(halted), 64'h0);
    chk({tag, "_err"}, 64'(err), 64'h0);
    chk({tag, "_count"}, 64'(count), 64'h0);
    chk({tag, "_stall"}, 64'(stall_cnt), 64'h0);
  endtask

  logic [63:0] ld[3];
  logic [63:0] cmp, lw, hw[9];
  logic [63:0] x;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    resume = 1'b0;
    #12;
    check_reset_values("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Three load-input instructions back to back
    for (int i = 0; i < 3; i++) ld[i] = mk(5'b00100);
    step(1, ld[0], 0);
    for (int i = 0; i < 3; i++) begin
      step(i < 2, (i < 2) ? ld[i+1] : 64'h0, 0);
      chk("t1_out", instr_out, ld[i]);
      chk("t1_vld", 64'(instr_valid), 64'h1);
    end
    step(0, 0, 0);
    chk("t1_count", 64'(count), 64'h0);
    chk("t1_idle_out", instr_out, 64'h0);

    // Compute window
    cmp = mk(5'b00001);
    lw  = mk(5'b00101);
    step(1, cmp, 0);
    step(1, lw, 0);
    chk("t2_cmp", instr_out, cmp);
    for (int i = 0; i < LAT; i++) begin
      step(0, 0, 0);
      chk("t2_nop", instr_out, 64'h0);
    end
    step(0, 0, 0);
    chk("t2_lw", instr_out, lw);
    chk("t2_lw_vld", 64'(instr_valid), 64'h1);

    // HALT, overfill, resume
    step(1, mk(5'b11111), 0);
    step(0, 0, 0);
    chk("t3_halted", 64'(halted), 64'h1);
    chk("t3_halt_vld", 64'(instr_valid), 64'h0);
    for (int i = 0; i < 9; i++) begin
      hw[i] = mk(fwd_op());
      step(1, hw[i], 0);
    end
    chk("t3_count_full", 64'(count), 64'd8);
    chk("t3_in_ready", 64'(in_ready), 64'h0);
    step(0, 0, 1);
    chk("t3_resumed", 64'(halted), 64'h0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      chk("t3_order", instr_out, hw[i]);
    end
    step(0, 0, 0);
    chk("t3_drained", 64'(count), 64'h0);

    // Illegal opcode then a legal one
    x = mk(5'b00111);
    step(1, mk(5'b01010), 0);
    step(1, x, 0);
    chk("t4_err", 64'(err), 64'h1);
    chk("t4_drop", 64'(instr_valid), 64'h0);
    step(0, 0, 0);
    chk("t4_fwd", instr_out, x);
    chk("t4_err_sticky", 64'(err), 64'h1);

    // Asynchronous reset in WAIT with four entries queued
    step(1, mk(5'b00010), 0);
    for (int i = 0; i < 4; i++) step(1, mk(fwd_op()), 0);
    chk("t5_count4", 64'(count), 64'd4);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("t5");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      chk("t5_no_issue", 64'(instr_valid), 64'h0);
    end

    // Stall counter over one compute window with one queued entry
    cmp = mk(5'b00001);
    x   = mk(5'b00011);
    step(1, cmp, 0);
    step(1, x, 0);
    for (int i = 0; i < LAT; i++) step(0, 0, 0);
    step(0, 0, 0);
    chk("t6_next", instr_out, x);
`ifdef SCHED_PERF_CNT_EN
    chk("t6_stall", 64'(stall_cnt), 64'd16);
`else
    chk("t6_stall", 64'(stall_cnt), 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [4:0] op;
      r = $urandom_range(0, 99);
      if (r < 60)      op = fwd_op();
      else if (r < 70) op = 5'($urandom_range(1, 2));
      else if (r < 76) op = 5'd31;
      else             op = 5'($urandom_range(8, 30));
      step($urandom_range(0, 99) < 70, mk(op), $urandom_range(0, 99) < 15);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
